tms320_pc_sequencer: RTL

//  Parametrised program sequencer for the TMS320 DSP core family: PC register, hardware return stack,
//  and a multi-line interrupt controller. Generalises the core's fixed 12-bit PC / 4-deep stack / single INT_N.

---
 rtl/tms320_seq_pkg.sv | 20 ++
 rtl/tms320_hw_stack.sv | 56 +++++
 rtl/tms320_pc_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/tms320_seq_pkg.sv
// Shared types and helpers for the TMS320 program sequencer.
// Holds the command encoding and the interrupt vector address calculation.
package tms320_seq_pkg;

    typedef enum logic [2:0] {
        CMD_HOLD = 3'd0,
        CMD_INC  = 3'd1,
        CMD_BR   = 3'd2,
        CMD_CALL = 3'd3,
        CMD_RET  = 3'd4,
        CMD_INT  = 3'd5,
        CMD_LDPC = 3'd6
    } seq_cmd_t;

    // Line i vectors to base + 2*i; caller truncates to its PC width (modulo wrap).
    function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [2:0] id);
        return base + {28'd0, id, 1'b0};
    endfunction

endpackage

// File: rtl/tms320_hw_stack.sv
// Hardware return stack: entry 0 is the top, pushes shift down and pops shift up.
// Overflow drops the bottom entry and underflow returns the stale bottom copy; both flags are sticky.
module tms320_hw_stack
    import tms320_seq_pkg::*;
#(
    parameter int PC_W  = 12,
    parameter int DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            ce,
    input  logic            srst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] tos,
    output logic            ovf,
    output logic            unf
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [PC_W-1:0]  stk [DEPTH];
    logic [CNT_W-1:0] cnt_q;

    assign tos = stk[0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
            cnt_q <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (ce) begin
            if (srst) begin
                for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
                cnt_q <= '0;
                ovf   <= 1'b0;
                unf   <= 1'b0;
            end else if (push) begin
                stk[0] <= din;
                for (int i = 1; i < DEPTH; i++) stk[i] <= stk[i-1];
                if (cnt_q == CNT_FULL) ovf <= 1'b1;
                else                   cnt_q <= cnt_q + CNT_ONE;
            end else if (pop) begin
                // Bottom entry is left in place so it gets duplicated upward.
                for (int i = 0; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
                if (cnt_q == '0) unf <= 1'b1;
                else             cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/tms320_pc_sequencer.sv
// Program sequencer: PC register, command mux, return stack and a prioritised,
// falling-edge interrupt controller. All state advances only on edges with EN & CE_R.
module tms320_pc_sequencer
    import tms320_seq_pkg::*;
#(
    parameter int              PC_W     = 12,
    parameter int              DEPTH    = 4,
    parameter int              NUM_INT  = 1,
    parameter logic [PC_W-1:0] VEC_BASE = 'h002,
    parameter logic [PC_W-1:0] RST_VEC  = 'h000
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               EN,
    input  logic               CE_R,
    input  logic               RS_N,
    input  seq_cmd_t           CMD,
    input  logic               COND,
    input  logic [PC_W-1:0]    TARGET,
    input  logic [NUM_INT-1:0] INT_N,
    input  logic [NUM_INT-1:0] INT_MASK,
    input  logic               INTM,
    output logic [PC_W-1:0]    PC,
    output logic [PC_W-1:0]    TOS,
    output logic               INT_REQ,
    output logic [2:0]         INT_ID,
    output logic               STK_OVF,
    output logic               STK_UNF
);

    logic               ce;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_nxt;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    pc_vec;
    logic [PC_W-1:0]    push_d;
    logic               push;
    logic               pop;
    logic               take_int;
    logic [NUM_INT-1:0] int_hist;
    logic [NUM_INT-1:0] pending;
    logic [NUM_INT-1:0] req_vec;
    logic [NUM_INT-1:0] clr_vec;
    logic [NUM_INT-1:0] fall_vec;

    assign ce       = EN & CE_R;
    assign PC       = pc_q;
    assign pc_inc   = pc_q + PC_W'(1);
    assign req_vec  = pending & ~INT_MASK;
    assign INT_REQ  = (|req_vec) & ~INTM;
    assign take_int = (CMD == CMD_INT) && INT_REQ;
    assign pc_vec   = PC_W'(vec_addr(32'(VEC_BASE), INT_ID));
    assign fall_vec = int_hist & ~INT_N;
    assign clr_vec  = take_int ? (NUM_INT'(1) << INT_ID) : '0;

    // Priority encoder: scan downward so the lowest requesting line wins.
    always_comb begin
        INT_ID = 3'd0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (req_vec[i]) INT_ID = 3'(i);
        end
    end

    always_comb begin
        pc_nxt = pc_q;
        push   = 1'b0;
        pop    = 1'b0;
        push_d = pc_inc;
        case (CMD)
            CMD_HOLD: pc_nxt = pc_q;
            CMD_INC:  pc_nxt = pc_inc;
            CMD_BR:   pc_nxt = COND ? TARGET : pc_inc;
            CMD_CALL: begin
                pc_nxt = COND ? TARGET : pc_inc;
                push   = COND;
            end
            CMD_RET: begin
                pc_nxt = TOS;
                pop    = 1'b1;
            end
            CMD_INT: begin
                // The interrupted instruction is re-fetched on return, so push PC itself.
                if (take_int) begin
                    pc_nxt = pc_vec;
                    push   = 1'b1;
                    push_d = pc_q;
                end
            end
            CMD_LDPC: pc_nxt = TARGET;
            default:  pc_nxt = pc_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q     <= RST_VEC;
            int_hist <= '1;
            pending  <= '0;
        end else if (ce) begin
            if (!RS_N) begin
                pc_q     <= RST_VEC;
                int_hist <= '1;
                pending  <= '0;
            end else begin
                pc_q     <= pc_nxt;
                int_hist <= INT_N;
                // A new edge on a line being serviced this cycle keeps it pending.
                pending  <= (pending & ~clr_vec) | fall_vec;
            end
        end
    end

    tms320_hw_stack #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_stack (
        .CLK   (CLK),
        .RST_N (RST_N),
        .ce    (ce),
        .srst  (~RS_N),
        .push  (push),
        .pop   (pop),
        .din   (push_d),
        .tos   (TOS),
        .ovf   (STK_OVF),
        .unf   (STK_UNF)
    );

endmodule
